// File: rtl/phasediff_pkg.sv
// Shared constants and FSM encoding for the phase-difference stage.
// Angles are signed degrees with ANG_FRAC fractional bits.
package phasediff_pkg;

    localparam int ANG_FRAC = 10;
    localparam int DEG180   = 180 << ANG_FRAC;
    localparam int DEG360   = 2 * DEG180;

    // WAIT_HI gives up on a busy rise after this many idle polls + 1
    localparam logic [1:0] HI_WAIT_MAX = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

endpackage

// File: rtl/phasediff_avg.sv
// Sliding-window mean of the last 2^AVGLOG phase differences.
// Running sum is updated incrementally; output is the floored mean.
module phasediff_avg
    import phasediff_pkg::*;
#(
    parameter int W      = 19,
    parameter int AVGLOG = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic signed [W-1:0] din,
    input  logic                din_valid,
    output logic signed [W-1:0] avg,
    output logic                avg_valid
);

    localparam int N  = 1 << AVGLOG;
    localparam int SW = W + AVGLOG;
    localparam logic [AVGLOG:0] FULL = (AVGLOG+1)'(N);

    logic signed [W-1:0]  win_q [N];
    logic signed [W-1:0]  win_d [N];
    logic signed [SW-1:0] sum_q, sum_d;
    logic [AVGLOG:0]      fill_q, fill_d;
    logic signed [W-1:0]  avg_q, avg_d;
    logic                 avg_valid_q, avg_valid_d;

    always_comb begin
        win_d       = win_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (din_valid) begin
            win_d[0] = din;
            for (int i = 1; i < N; i++) begin
                win_d[i] = win_q[i-1];
            end
            sum_d = sum_q + SW'(din) - SW'(win_q[N-1]);
            if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
            avg_d       = W'(sum_d >>> AVGLOG);
            avg_valid_d = (fill_d == FULL);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            fill_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg       = avg_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: rtl/phasediff.sv
// Sequences one phase-calculator conversion per sample and emits the
// wrapped sample-to-sample angle difference plus its window mean.
module phasediff
    import phasediff_pkg::*;
#(
    parameter int ANGSIZE = 19,
    parameter int AVGLOG  = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      smp_valid,
    output logic                      pc_start,
    input  logic                      pc_busy,
    input  logic signed [ANGSIZE-1:0] angle,
    output logic signed [ANGSIZE-1:0] dphase,
    output logic                      dphase_valid,
    output logic signed [ANGSIZE-1:0] freq_avg,
    output logic                      avg_valid,
    output logic                      overrun
);

    localparam int DW = ANGSIZE + 1;
    localparam logic signed [DW-1:0] D180 = DW'(DEG180);
    localparam logic signed [DW-1:0] D360 = DW'(DEG360);

    state_t                     state_q, state_d;
    logic [1:0]                 hi_cnt_q, hi_cnt_d;
    logic signed [ANGSIZE-1:0]  prev_q, prev_d;
    logic                       have_prev_q, have_prev_d;
    logic signed [ANGSIZE-1:0]  dphase_q, dphase_d;
    logic                       dphase_valid_q, dphase_valid_d;
    logic                       overrun_q, overrun_d;
    logic signed [DW-1:0]       diff_raw;
    logic signed [ANGSIZE-1:0]  diff_wrap;

    always_comb begin
        diff_raw = DW'(angle) - DW'(prev_q);
        if (diff_raw > D180) begin
            diff_wrap = ANGSIZE'(diff_raw - D360);
        end else if (diff_raw <= -D180) begin
            diff_wrap = ANGSIZE'(diff_raw + D360);
        end else begin
            diff_wrap = ANGSIZE'(diff_raw);
        end
    end

    always_comb begin
        state_d        = state_q;
        hi_cnt_d       = hi_cnt_q;
        prev_d         = prev_q;
        have_prev_d    = have_prev_q;
        dphase_d       = dphase_q;
        dphase_valid_d = 1'b0;
        overrun_d      = overrun_q;
        pc_start       = 1'b0;

        // Samples arriving while a conversion is in flight are dropped
        if (smp_valid && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (smp_valid) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                pc_start = 1'b1;
                hi_cnt_d = '0;
                state_d  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (pc_busy) begin
                    state_d = S_WAIT_LO;
                end else if (hi_cnt_q == HI_WAIT_MAX) begin
                    state_d = S_CAPTURE;
                end else begin
                    hi_cnt_d = hi_cnt_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!pc_busy) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                prev_d      = angle;
                have_prev_d = 1'b1;
                if (have_prev_q) begin
                    dphase_d       = diff_wrap;
                    dphase_valid_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            hi_cnt_q       <= '0;
            prev_q         <= '0;
            have_prev_q    <= 1'b0;
            dphase_q       <= '0;
            dphase_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hi_cnt_q       <= hi_cnt_d;
            prev_q         <= prev_d;
            have_prev_q    <= have_prev_d;
            dphase_q       <= dphase_d;
            dphase_valid_q <= dphase_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    phasediff_avg #(
        .W      (ANGSIZE),
        .AVGLOG (AVGLOG)
    ) u_avg (
        .clock     (clock),
        .reset     (reset),
        .din       (dphase_q),
        .din_valid (dphase_valid_q),
        .avg       (freq_avg),
        .avg_valid (avg_valid)
    );

    assign dphase       = dphase_q;
    assign dphase_valid = dphase_valid_q;
    assign overrun      = overrun_q;

endmodule
